// File: rtl/ksa_pkg.sv
// ksa_pkg: shared types and defaults for the key search scheduler
package ksa_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;
    localparam int KSA_KEY_WIDTH = 24;
    localparam logic [KSA_KEY_WIDTH:0] KSA_KEY_LIMIT = 25'h0400000;
endpackage

// File: rtl/key_search_scheduler_rr_idle_picker.sv
// rr_idle_picker: combinational round-robin picker, first request at or after ptr
module rr_idle_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);
    int j;
    // scan upward from ptr with wrap and grant the first requester
    always_comb begin
        grant = '0;
        valid = 1'b0;
        j = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                grant[j] = 1'b1;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/key_search_scheduler.sv
// key_search_scheduler: dispatches consecutive RC4 trial keys over a core bank; SCHED_ABORT_EN adds core_abort on a find
module key_search_scheduler
    import ksa_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = KSA_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH:0]   KEY_LIMIT = KSA_KEY_LIMIT
) (
    input  logic                           CLOCK_50,
    input  logic                           reset_n,
    input  logic                           start,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
`ifdef SCHED_ABORT_EN
    output logic [NUM_CORES-1:0]           core_abort,
`endif
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key
);
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    sched_state_t                   state_q, state_d;
    logic [NUM_CORES-1:0]           cbusy_q, cbusy_d;
    logic [KEY_WIDTH:0]             next_key_q, next_key_d;
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [NUM_CORES*KEY_WIDTH-1:0] key_q, key_d;
    logic                           found_q, found_d;
    logic                           exh_q, exh_d;
    logic [KEY_WIDTH-1:0]           fkey_q, fkey_d;
    logic [NUM_CORES-1:0]           retire, live, idle, fnd_req, disp_grant, fnd_grant;
    logic                           disp_valid, fnd_valid;
    int                             didx, fidx;

    assign retire  = core_done & cbusy_q;
    assign live    = cbusy_q & ~retire;
    assign idle    = ~live;
    assign fnd_req = retire & core_found;

    rr_idle_picker #(.N(NUM_CORES), .PW(PW)) u_disp (
        .req(idle), .ptr(ptr_q), .grant(disp_grant), .valid(disp_valid)
    );

    rr_idle_picker #(.N(NUM_CORES), .PW(PW)) u_fnd (
        .req(fnd_req), .ptr('0), .grant(fnd_grant), .valid(fnd_valid)
    );

    // convert one-hot grants to core indices for key slicing
    always_comb begin
        didx = 0;
        fidx = 0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            didx = disp_grant[c] ? c : didx;
            fidx = fnd_grant[c] ? c : fidx;
        end
    end

    // next-state: retire, found check, dispatch, exhaustion
    always_comb begin
        state_d    = state_q;
        cbusy_d    = cbusy_q;
        next_key_d = next_key_q;
        ptr_d      = ptr_q;
        key_d      = key_q;
        found_d    = found_q;
        exh_d      = exh_q;
        fkey_d     = fkey_q;
        core_start = '0;
`ifdef SCHED_ABORT_EN
        core_abort = '0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    next_key_d = {1'b0, KEY_START};
                    found_d    = 1'b0;
                    exh_d      = 1'b0;
                    fkey_d     = '0;
                end
            end
            RUN: begin
                cbusy_d = live;
                if (fnd_valid) begin
                    fkey_d = key_q[fidx*KEY_WIDTH +: KEY_WIDTH];
`ifdef SCHED_ABORT_EN
                    core_abort = live;
                    cbusy_d    = '0;
                    found_d    = 1'b1;
                    state_d    = DONE;
`else
                    state_d    = DRAIN;
`endif
                end else begin
                    if (next_key_q < KEY_LIMIT && disp_valid) begin
                        core_start                          = disp_grant;
                        key_d[didx*KEY_WIDTH +: KEY_WIDTH] = next_key_q[KEY_WIDTH-1:0];
                        cbusy_d                             = live | disp_grant;
                        next_key_d                          = next_key_q + 1'b1;
                        ptr_d                               = PW'((didx + 1) % NUM_CORES);
                    end
                    if (next_key_q >= KEY_LIMIT && live == '0) begin
                        exh_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DRAIN: begin
                cbusy_d = live;
                if (live == '0) begin
                    found_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with asynchronous clear
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cbusy_q    <= '0;
            next_key_q <= '0;
            ptr_q      <= '0;
            key_q      <= '0;
            found_q    <= 1'b0;
            exh_q      <= 1'b0;
            fkey_q     <= '0;
        end else begin
            state_q    <= state_d;
            cbusy_q    <= cbusy_d;
            next_key_q <= next_key_d;
            ptr_q      <= ptr_d;
            key_q      <= key_d;
            found_q    <= found_d;
            exh_q      <= exh_d;
            fkey_q     <= fkey_d;
        end
    end

    assign core_key  = key_d;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign found     = found_q;
    assign exhausted = exh_q;
    assign found_key = fkey_q;
endmodule

// File: tb/tb_key_search_scheduler.sv
// tb_key_search_scheduler: stub cores plus scoreboard of search results and launch rules
module tb_key_search_scheduler;
    localparam int N  = 4;
    localparam int KW = 24;
    localparam int L  = 8;
    localparam logic [KW:0] LIM = 25'd8;

    typedef struct {
        bit f;
        bit e;
        int k;
    } res_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [N-1:0]    core_start, core_done, core_found;
    logic [N*KW-1:0] core_key;
    logic            busy, found, exhausted;
    logic [KW-1:0]   found_key;
`ifdef SCHED_ABORT_EN
    logic [N-1:0]    core_abort;
`endif

    key_search_scheduler #(
        .NUM_CORES(N), .KEY_WIDTH(KW), .KEY_START('0), .KEY_LIMIT(LIM)
    ) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .start(start),
        .core_start(core_start), .core_key(core_key),
        .core_done(core_done), .core_found(core_found),
`ifdef SCHED_ABORT_EN
        .core_abort(core_abort),
`endif
        .busy(busy), .found(found), .exhausted(exhausted), .found_key(found_key)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   lat[L];
    bit   fset[L];
    bit   mb[N];
    int   mkey[N];
    int   rem[N];
    bit   pend[N];
    int   m_next = 0;
    int   m_ptr = 0;
    bit   m_active = 0;
    bit   find_seen = 0;
    bit   find_now = 0;
    bit   pushed = 0;
    bit   spur_en = 0;
    bit   first_launch = 0;
    bit   prev_busy = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   results = 0;
    res_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // stub core outputs driven just after each rising edge
    logic [N-1:0] dd, df;
    int           w, sc;
    bit           anyb;
    always @(posedge clk) begin
        #1;
        find_now = 0;
        dd = '0;
        df = '0;
        if (rst_n) begin
            for (int c = 0; c < N; c++) if (pend[c]) begin
                dd[c] = 1'b1;
                df[c] = fset[mkey[c]];
            end
            if (spur_en && $urandom_range(3) == 0) begin
                sc = $urandom_range(N - 1);
                if (!mb[sc] && !pend[sc]) begin
                    dd[sc] = 1'b1;
                    df[sc] = 1'b1;
                end
            end
            if (m_active && !pushed) begin
                w = -1;
                for (int c = 0; c < N; c++) if (dd[c] && mb[c] && df[c] && w < 0) w = c;
                if (w >= 0) begin
                    exp_q.push_back('{1'b1, 1'b0, mkey[w]});
                    pushed = 1;
                    find_seen = 1;
                    find_now = 1;
                end
            end
            for (int c = 0; c < N; c++) if (dd[c] && mb[c]) mb[c] = 0;
            anyb = 0;
            for (int c = 0; c < N; c++) anyb |= mb[c];
            if (m_active && !pushed && m_next == L && !anyb) begin
                exp_q.push_back('{1'b0, 1'b1, 0});
                pushed = 1;
            end
        end
        core_done = dd;
        core_found = df;
    end

    // monitor: launches, stub timing, result scoreboard
    int nl, ec, jj;
    logic [N-1:0] mbv;
    res_t r;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                mb[c] = 0;
                rem[c] = 0;
                pend[c] = 0;
            end
            exp_q.delete();
            m_active = 0;
            pushed = 0;
            find_seen = 0;
            prev_busy = 0;
            m_next = 0;
            m_ptr = 0;
        end else begin
            for (int c = 0; c < N; c++) if (rem[c] > 0) rem[c]--;
            nl = 0;
            for (int c = 0; c < N; c++) if (core_start[c]) begin
                nl++;
                ec = -1;
                for (int i = 0; i < N; i++) begin
                    jj = (m_ptr + i) % N;
                    if (!mb[jj] && ec < 0) ec = jj;
                end
                chk("launch_core", c, ec);
                chk("launch_key", core_key[c*KW +: KW], m_next);
                chk("launch_after_find", find_seen, 0);
                if (first_launch) begin
                    chk("start_latency", cyc - start_cyc, 1);
                    first_launch = 0;
                end
                mkey[c] = m_next;
                m_next++;
                m_ptr = (c + 1) % N;
                mb[c] = 1;
                rem[c] = (mkey[c] < L) ? lat[mkey[c]] : 1;
            end
            if (nl > 0) chk("one_dispatch", nl, 1);
`ifdef SCHED_ABORT_EN
            if (find_now) begin
                for (int c = 0; c < N; c++) mbv[c] = mb[c];
                chk("core_abort", core_abort, mbv);
                for (int c = 0; c < N; c++) begin
                    mb[c] = 0;
                    rem[c] = 0;
                end
            end
`endif
            for (int c = 0; c < N; c++) pend[c] = (rem[c] == 1);
            if (busy) chk("found_while_busy", found, 0);
            if (prev_busy && !busy) begin
                results++;
                m_active = 0;
                chk("result_present", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    chk("res_found", found, r.f);
                    chk("res_exhausted", exhausted, r.e);
                    chk("res_found_key", found_key, r.k);
                end
            end
            if (start && !busy) begin
                m_active = 1;
                m_next = 0;
                find_seen = 0;
                pushed = 0;
                first_launch = 1;
                start_cyc = cyc;
            end
            prev_busy = busy;
        end
    end

    task automatic reset_outputs_zero();
        chk("rst_core_start", core_start, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_busy", busy, 0);
        chk("rst_found", found, 0);
        chk("rst_exhausted", exhausted, 0);
        chk("rst_found_key", found_key, 0);
    endtask

    task automatic set_cfg(input int l, input int fk);
        for (int k = 0; k < L; k++) begin
            lat[k] = l;
            fset[k] = (k == fk);
        end
    endtask

    task automatic run_search(input bit mid);
        int r0;
        r0 = results;
        @(posedge clk);
        #1 start = 1'b1;
        for (int i = 0; i < 600 && results == r0; i++) begin
            @(posedge clk);
            #1 start = mid && i == 4 && busy;
        end
        start = 1'b0;
        chk("search_done", results != r0, 1);
    endtask

    initial begin
        set_cfg(10, -1);
        core_done = '0;
        core_found = '0;
        repeat (3) @(posedge clk);
        #1 reset_outputs_zero();
        rst_n = 1'b1;
        run_search(1'b0);
        set_cfg(10, -1);
        lat[1] = 12;
        fset[1] = 1;
        fset[3] = 1;
        run_search(1'b0);
        set_cfg(10, 5);
        run_search(1'b1);
        set_cfg(10, -1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 reset_outputs_zero();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_search(1'b0);
        spur_en = 1;
        run_search(1'b1);
        for (int s = 0; s < 12; s++) begin
            for (int k = 0; k < L; k++) begin
                lat[k] = $urandom_range(14, 1);
                fset[k] = ($urandom_range(3) == 0);
            end
            spur_en = $urandom_range(1);
            run_search($urandom_range(1));
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
